fetch_queue: RTL and testbench

//  Instruction prefetch stage between the instruction ROM (1-cycle registered read) and the core.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_inst_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 112 +++++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch path (package defs).
// Instruction is the ROM word; FetchEntry pairs it with the address it came from.
package defs;

    localparam int IMEM_ADDR_W = 8;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] reg_sel;
        logic [7:0] operand;
    } Instruction;

    typedef struct packed {
        Instruction             inst;
        logic [IMEM_ADDR_W-1:0] pc;
    } FetchEntry;

endpackage

// File: rtl/fetch_queue_inst_fifo.sv
// inst_fifo: DEPTH-entry FetchEntry queue with push/pop/flush and an occupancy count.
// Head is read straight from storage at the registered read pointer; a pushed
// entry becomes visible on the following cycle.
module inst_fifo
    import defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  FetchEntry              wdata,
    input  logic                   pop,
    input  logic                   flush,
    output FetchEntry              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    FetchEntry        mem [DEPTH];

    // Storage, pointers and occupancy; flush drops everything including a same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Head entry as seen by the consumer.
    always_comb begin
        head = mem[rd_ptr];
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch between a 1-cycle registered ROM and the core.
// Issues sequential addresses under credit control, buffers returns with their PC,
// and restarts from redirect_addr on a redirect.
// Optional statistics (stall_cnt, flush_cnt) are built when FETCH_STATS_EN is defined.
module fetch_queue
    import defs::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  Instruction        imem_data,
    output logic              inst_valid,
    output Instruction        inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credits;
    logic              issue;
    logic              push;
    logic              pop;
    FetchEntry         wentry;
    FetchEntry         head;

    // Address to the ROM and credit check; a redirect frees all credits immediately.
    always_comb begin
        if (rst) begin
            imem_addr = '0;
        end else if (redirect_valid) begin
            imem_addr = redirect_addr;
        end else begin
            imem_addr = fetch_pc;
        end
        credits = redirect_valid ? '0 : ({1'b0, count} + (CNT_W+1)'(inflight));
        issue   = !rst && (credits < (CNT_W+1)'(DEPTH));
        push    = inflight && !redirect_valid;
        pop     = inst_valid && inst_ready;
        wentry  = '{inst: imem_data, pc: inflight_pc};
    end

    // Fetch PC and single outstanding-read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (issue) begin
            fetch_pc    <= imem_addr + ADDR_W'(1);
            inflight    <= 1'b1;
            inflight_pc <= imem_addr;
        end else begin
            inflight <= 1'b0;
            if (redirect_valid) begin
                fetch_pc <= redirect_addr;
            end
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .count (count)
    );

    // Head presentation to the core.
    always_comb begin
        inst_valid = (count != '0);
        inst       = head.inst;
        inst_pc    = head.pc;
    end

`ifdef FETCH_STATS_EN
    // Saturating counts of empty-head cycles and redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!inst_valid && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (redirect_valid && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue with a registered ROM model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        inst_valid;
    logic [15:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
`ifdef FETCH_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    int          stall_m = 0;
    int          flush_m = 0;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst;
        logic       ready;
        logic       redir;
        logic [7:0] raddr;
        logic [7:0] e_addr;
        logic       e_valid;
        logic       chk_pc;
        logic [7:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    fetch_queue #(
        .DEPTH  (4),
        .ADDR_W (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
`ifdef FETCH_STATS_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [7:0] a);
        return {a ^ 8'hA5, a};
    endfunction

    // Registered ROM: data for the address driven in the previous cycle.
    always @(posedge clk) imem_data <= rom(imem_addr);

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [7:0] ra,
                                input logic [7:0] ea, input logic ev, input logic cp, input logic [7:0] ep);
        vec_t v;
        v.rst = r; v.ready = rdy; v.redir = rv; v.raddr = ra;
        v.e_addr = ea; v.e_valid = ev; v.chk_pc = cp; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compares one cycle at negedge, advances the stats model, then lets the edge happen.
    task automatic run_cycle(input string tag, input vec_t v);
        rst            = v.rst;
        inst_ready     = v.ready;
        redirect_valid = v.redir;
        redirect_addr  = v.raddr;
        @(negedge clk);
        chk({tag, " imem_addr"}, 32'(imem_addr), 32'(v.e_addr));
        chk({tag, " inst_valid"}, 32'(inst_valid), 32'(v.e_valid));
        if (v.chk_pc || v.e_valid) chk({tag, " inst_pc"}, 32'(inst_pc), 32'(v.e_pc));
        if (v.e_valid) chk({tag, " inst"}, 32'(inst), 32'(rom(v.e_pc)));
`ifdef FETCH_STATS_EN
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
        chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'(flush_m));
        if (v.rst) begin
            stall_m = 0;
            flush_m = 0;
        end else begin
            if (!v.e_valid) stall_m++;
            if (v.redir) flush_m++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Startup: 2 reset cycles, then sequential fetch with ready held high.
        vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h01, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h02, 1, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h03, 1, 1, 8'h01));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h04, 1, 1, 8'h02));
        // Mid-stream reset, then ready low for 10 cycles: 4 issues, address stuck at 4.
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h03));
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 1, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h02, 1, 1, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h03, 1, 1, 8'h00));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 0, 8'h00, 8'h04, 1, 1, 8'h00));
        // Drain in order, fetch resumes once a credit frees.
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h04, 1, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h04, 1, 1, 8'h01));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h05, 1, 1, 8'h02));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h06, 1, 1, 8'h03));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h07, 1, 1, 8'h04));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h08, 1, 1, 8'h05));
        // Reset, fill 3 entries + 1 inflight, redirect to 0x40.
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h06));
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 1, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h02, 1, 1, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h03, 1, 1, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'h40, 8'h40, 1, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h41, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h42, 1, 1, 8'h40));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h43, 1, 1, 8'h41));
        // Redirect to 0xFE with pop in the same cycle; addresses wrap.
        vecs.push_back(mk(0, 1, 1, 8'hFE, 8'hFE, 1, 1, 8'h42));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'hFF, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 1, 1, 8'hFE));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h01, 1, 1, 8'hFF));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h02, 1, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h03, 1, 1, 8'h01));
        // Redirect+pop, then back-to-back redirects: only 0x90 is fetched.
        vecs.push_back(mk(0, 1, 1, 8'h80, 8'h80, 1, 1, 8'h02));
        vecs.push_back(mk(0, 1, 1, 8'h90, 8'h90, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h91, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h92, 1, 1, 8'h90));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h93, 1, 1, 8'h91));
        // Fill the queue, then reset with it full.
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h94, 1, 1, 8'h92));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h95, 1, 1, 8'h92));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h96, 1, 1, 8'h92));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h96, 1, 1, 8'h92));
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h92));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h01, 0, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h02, 1, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h03, 1, 1, 8'h01));

        rst            = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_cycle($sformatf("vec%0d", i), vecs[i]);
        end

        // Steady state: one instruction per cycle with ready held high.
        for (int k = 0; k < 16; k++) begin
            logic [7:0] ea;
            logic [7:0] ep;
            ea = 8'(4 + k);
            ep = 8'(2 + k);
            run_cycle($sformatf("steady%0d", k), mk(0, 1, 0, 8'h00, ea, 1, 1, ep));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
